ram_sdp_sync_pipe: RTL and testbench

- Parametrised simple-dual-port RAM: one write port and one independent read port on a single clock.
- Synchronous read with an optional output register stage and per-byte write enables.
- Selectable read-during-write behaviour.
- A built-in clear engine zeroes the array after reset or on request.
- Successor to the single-port synchronous-read RAM; used as general storage for buffers and lookup tables.

---
 rtl/ram_sdp_sync_pipe.sv | 146 ++++++++++++++
 tb/tb_ram_sdp_sync_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_sync_pipe.sv
// Simple-dual-port RAM with byte enables, registered read, optional output stage
// and a clear engine that zeroes every word after reset or on request.
module ram_sdp_sync_pipe #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_req,
    output logic                  busy
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

    logic              rd_accept;
    logic              wr_accept;
    logic [NB-1:0]     mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid_reg;

    assign busy      = (state_reg == CLEAR);
    assign rd_accept = rd_en && !busy;
    assign wr_accept = wr_en && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == CNT_LAST) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // The clear engine owns the write port whenever it is running.
    always_comb begin
        mem_we    = wr_accept ? wr_be : '0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_reg == CLEAR) begin
            mem_we    = '1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = '0;
        end
    end

    // One narrow array per byte lane keeps byte writes a plain lane enable.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];
        logic [7:0] s1_byte_reg;
        logic       bypass;

        assign bypass = (RDW_MODE != 0) && mem_we[gi] && (mem_waddr == rd_addr);

        always_ff @(posedge clk) begin
            if (mem_we[gi]) begin
                mem_lane[mem_waddr] <= mem_wdata[8*gi +: 8];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_byte_reg <= '0;
            end else if (rd_accept) begin
                s1_byte_reg <= bypass ? mem_wdata[8*gi +: 8] : mem_lane[rd_addr];
            end
        end

        assign s1_data[8*gi +: 8] = s1_byte_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= rd_accept;
        end
    end

    // The output stage drains regardless of busy so in-flight reads complete.
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] out_data_reg;
        logic              out_valid_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data_reg  <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= s1_data;
                end
            end
        end

        assign rd_data  = out_data_reg;
        assign rd_valid = out_valid_reg;
    end else begin : g_no_out_reg
        assign rd_data  = s1_data;
        assign rd_valid = s1_valid_reg;
    end

endmodule

// File: tb/tb_ram_sdp_sync_pipe.sv
// Directed bench: dut0 (latency 1, old-data RDW) and dut1 (latency 2, new-data RDW)
// share stimulus; expected read data is supplied by hand per DUT.
module tb_ram_sdp_sync_pipe;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        clr_req;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int          n_total;
    int          n_bad;
    logic        q1_v;
    logic [15:0] q1_d;

    ram_sdp_sync_pipe #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .clr_req(clr_req), .busy(busy0)
    );

    ram_sdp_sync_pipe #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clr_req(clr_req), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; acc says whether the read should be accepted.
    task automatic cyc(input logic re, input logic [3:0] ra, input logic [15:0] e0,
                       input logic [15:0] e1, input logic acc, input logic we,
                       input logic [3:0] wa, input logic [1:0] be, input logic [15:0] wd,
                       input logic cr);
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        clr_req = cr;
        @(posedge clk);
        #1;
        $display("%0t re=%0b ra=%0d we=%0b wa=%0d be=%b wd=%h clr=%0b | d0=%h v0=%0b d1=%h v1=%0b",
                 $time, re, ra, we, wa, be, wd, cr, rd_data0, rd_valid0, rd_data1, rd_valid1);
        chk("valid0", rd_valid0, acc);
        if (acc) chk("data0", rd_data0, e0);
        chk("valid1", rd_valid1, q1_v);
        if (q1_v) chk("data1", rd_data1, q1_d);
        q1_v = acc;
        q1_d = e1;
    endtask

    task automatic rd(input logic [3:0] ra, input logic [15:0] e0, input logic [15:0] e1);
        cyc(1'b1, ra, e0, e1, 1'b1, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [1:0] be, input logic [15:0] wd);
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, wa, be, wd, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0);
    endtask

    // Hammer the ports while busy; the edge count until busy drops must be 16.
    task automatic wait_clear(input string tag);
        int n;
        for (n = 1; n <= 40; n++) begin
            cyc(1'b1, n[3:0], 16'h0, 16'h0, 1'b0, 1'b1, n[3:0], 2'b11, 16'hFFFF, 1'b0);
            if (!busy0) break;
        end
        chk(tag, n, 16);
        chk("busy1_done", busy1, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        rst_n = 1'b0;
        q1_v  = 1'b0;
        #1;
        chk("rst_busy0", busy0, 1'b1);
        chk("rst_busy1", busy1, 1'b1);
        chk("rst_valid0", rd_valid0, 1'b0);
        chk("rst_valid1", rd_valid1, 1'b0);
        chk("rst_data0", rd_data0, 16'h0);
        chk("rst_data1", rd_data1, 16'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(tag);
    endtask

    initial begin
        n_total = 0; n_bad = 0; q1_v = 1'b0; q1_d = 16'h0;
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_be = 2'b00; wr_data = 16'h0;
        rd_en = 1'b0; rd_addr = 4'd0; clr_req = 1'b0;
        #2;
        do_reset("clr_len_after_reset");

        for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, 16'h0000);
        idle(); idle();

        wr(4'd1, 2'b11, 16'hAAAA);
        wr(4'd2, 2'b11, 16'h55FF);
        rd(4'd1, 16'hAAAA, 16'hAAAA);
        rd(4'd2, 16'h55FF, 16'h55FF);
        idle(); idle();
        chk("hold0", rd_data0, 16'h55FF);
        chk("hold1", rd_data1, 16'h55FF);

        wr(4'd3, 2'b11, 16'h1234);
        wr(4'd3, 2'b10, 16'hABCD);
        wr(4'd3, 2'b00, 16'hFFFF);
        rd(4'd3, 16'hAB34, 16'hAB34);

        wr(4'd5, 2'b11, 16'h1111);
        cyc(1'b1, 4'd5, 16'h1111, 16'h2222, 1'b1, 1'b1, 4'd5, 2'b11, 16'h2222, 1'b0);
        rd(4'd5, 16'h2222, 16'h2222);
        cyc(1'b1, 4'd5, 16'h2222, 16'h3322, 1'b1, 1'b1, 4'd5, 2'b10, 16'h3300, 1'b0);
        rd(4'd5, 16'h3322, 16'h3322);

        cyc(1'b1, 4'd1, 16'hAAAA, 16'hAAAA, 1'b1, 1'b1, 4'd6, 2'b11, 16'h7777, 1'b0);
        rd(4'd6, 16'h7777, 16'h7777);
        idle(); idle();

        // Request clear with a read and write in the same cycle; both still happen.
        cyc(1'b1, 4'd1, 16'hAAAA, 16'hAAAA, 1'b1, 1'b1, 4'd7, 2'b11, 16'hBEEF, 1'b1);
        wait_clear("clr_len_after_req");
        rd(4'd1, 16'h0000, 16'h0000);
        rd(4'd7, 16'h0000, 16'h0000);
        rd(4'd5, 16'h0000, 16'h0000);
        idle(); idle();

        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1);
        repeat (5) idle();
        do_reset("clr_len_after_mid_clear_reset");

        wr(4'd8, 2'b11, 16'h4321);
        rd(4'd8, 16'h4321, 16'h4321);
        do_reset("clr_len_after_inflight_reset");
        rd(4'd8, 16'h0000, 16'h0000);
        idle(); idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
